// File: rtl/dds_param_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dds_param_ctrl
// Purpose  : Turns four raw active-low push buttons into DDS control words.
//            Each key is synchronised (2 flops) and debounced, and a falling
//            edge of the debounced level produces a one-clock press pulse.
//            Press pulses rotate the waveform select, step the frequency
//            tuning word up/down with clamping, and advance the phase word.
// Ports    : clk         - system clock, rising edge
//            rstn        - asynchronous active-low reset
//            key_wave    - raw button, next waveform
//            key_fre_up  - raw button, frequency up
//            key_fre_dn  - raw button, frequency down
//            key_pha     - raw button, phase advance
//            wave_sel    - one-hot waveform select (sin/square/tri/saw)
//            fre_step    - N-bit frequency tuning word
//            pha_step    - M-bit phase offset word
//            param_upd   - one-clock pulse when any output word changes
// Revision : 1.0 - initial release
// ============================================================================
module dds_param_ctrl #(
  parameter int N               = 32,
  parameter int M               = 12,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int FRE_INIT        = 86,
  parameter int FRE_INC         = 86,
  parameter int FRE_MAX         = 858993459,
  parameter int PHA_INC         = 1024
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         key_wave,
  input  logic         key_fre_up,
  input  logic         key_fre_dn,
  input  logic         key_pha,
  output logic [3:0]   wave_sel,
  output logic [N-1:0] fre_step,
  output logic [M-1:0] pha_step,
  output logic         param_upd
);

  localparam int            CW         = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] C_CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [N-1:0]  C_FRE_INIT = N'(FRE_INIT);
  localparam logic [N-1:0]  C_FRE_INC  = N'(FRE_INC);
  localparam logic [N-1:0]  C_FRE_MAX  = N'(FRE_MAX);
  localparam logic [N:0]    C_INC_X    = (N+1)'(FRE_INC);
  localparam logic [N:0]    C_INC2_X   = (N+1)'(2 * FRE_INC);
  localparam logic [N:0]    C_MAX_X    = (N+1)'(FRE_MAX);
  localparam logic [M-1:0]  C_PHA_INC  = M'(PHA_INC);

  // Key index: 0 wave, 1 fre_up, 2 fre_dn, 3 pha
  logic [3:0] keys_raw;
  logic [3:0] press;

  assign keys_raw = {key_pha, key_fre_dn, key_fre_up, key_wave};

  generate
    for (genvar k = 0; k < 4; k++) begin : g_key
      logic          sync1_q;
      logic          sync2_q;
      logic          stable_q;
      logic          stable_d;
      logic          press_q;
      logic          press_d;
      logic [CW-1:0] cnt_q;
      logic [CW-1:0] cnt_d;

      // Counter runs only while the synchronised level disagrees with the
      // accepted level; any agreeing cycle restarts the stability window.
      always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync2_q != stable_q) begin
          if (cnt_q == C_CNT_LAST) begin
            stable_d = sync2_q;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        // Only a 1 -> 0 change of the accepted level counts as a press
        press_d = stable_q & ~stable_d;
      end

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          sync1_q  <= 1'b1;
          sync2_q  <= 1'b1;
          stable_q <= 1'b1;
          cnt_q    <= '0;
          press_q  <= 1'b0;
        end else begin
          sync1_q  <= keys_raw[k];
          sync2_q  <= sync1_q;
          stable_q <= stable_d;
          cnt_q    <= cnt_d;
          press_q  <= press_d;
        end
      end

      assign press[k] = press_q;
    end
  endgenerate

  logic [3:0]   wave_q, wave_d;
  logic [N-1:0] fre_q, fre_d;
  logic [M-1:0] pha_q, pha_d;
  logic         upd_q, upd_d;
  logic [N:0]   fre_sum;

  always_comb begin
    wave_d  = wave_q;
    fre_d   = fre_q;
    pha_d   = pha_q;
    // One extra bit so the up-step can never wrap past the clamp
    fre_sum = {1'b0, fre_q} + C_INC_X;

    if (press[0]) begin
      case (wave_q)
        4'b0001: wave_d = 4'b0010;
        4'b0010: wave_d = 4'b0100;
        4'b0100: wave_d = 4'b1000;
        4'b1000: wave_d = 4'b0001;
        default: wave_d = 4'b0001;
      endcase
    end

    // Simultaneous up and down cancel out
    if (press[1] && !press[2]) begin
      fre_d = (fre_sum > C_MAX_X) ? C_FRE_MAX : fre_sum[N-1:0];
    end else if (press[2] && !press[1]) begin
      // Floor at one step so the tuning word never reaches zero
      fre_d = ({1'b0, fre_q} <= C_INC2_X) ? C_FRE_INC : (fre_q - C_FRE_INC);
    end

    if (press[3]) begin
      pha_d = pha_q + C_PHA_INC;
    end

    upd_d = (wave_d != wave_q) || (fre_d != fre_q) || (pha_d != pha_q);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wave_q <= 4'b0001;
      fre_q  <= C_FRE_INIT;
      pha_q  <= '0;
      upd_q  <= 1'b0;
    end else begin
      wave_q <= wave_d;
      fre_q  <= fre_d;
      pha_q  <= pha_d;
      upd_q  <= upd_d;
    end
  end

  assign wave_sel  = wave_q;
  assign fre_step  = fre_q;
  assign pha_step  = pha_q;
  assign param_upd = upd_q;

endmodule
`default_nettype wire

// File: tb/tb_dds_param_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dds_param_ctrl
// Purpose  : Directed self-checking bench for dds_param_ctrl with a short
//            debounce window. Expected words are queued when a key is
//            driven and popped when the update edge arrives.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dds_param_ctrl;

  localparam int N  = 32;
  localparam int M  = 12;
  localparam int DB = 4;
  localparam int LAT = DB + 3;   // edges from first low sample to update

  typedef struct {
    logic [3:0]  w;
    logic [31:0] f;
    logic [11:0] p;
    logic        u;
  } exp_t;

  logic         clk = 1'b0;
  logic         rstn;
  logic [3:0]   keys;          // 0 wave, 1 fre_up, 2 fre_dn, 3 pha
  logic [3:0]   wave_sel;
  logic [N-1:0] fre_step;
  logic [M-1:0] pha_step;
  logic         param_upd;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  exp_t cur;

  always #5 clk = ~clk;

  dds_param_ctrl #(
    .N(N), .M(M), .DEBOUNCE_CYCLES(DB), .FRE_INIT(86), .FRE_INC(86),
    .FRE_MAX(300), .PHA_INC(1024)
  ) dut (
    .clk(clk), .rstn(rstn),
    .key_wave(keys[0]), .key_fre_up(keys[1]), .key_fre_dn(keys[2]), .key_pha(keys[3]),
    .wave_sel(wave_sel), .fre_step(fre_step), .pha_step(pha_step), .param_upd(param_upd)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_words(input string tag);
    chk({tag, "_wave"}, {28'd0, wave_sel}, {28'd0, cur.w});
    chk({tag, "_fre"},  fre_step,          cur.f);
    chk({tag, "_pha"},  {20'd0, pha_step}, {20'd0, cur.p});
  endtask

  // Hold the masked keys low for 'hold' edges, then release; the update
  // must land exactly LAT edges after the first low sample.
  task automatic press(input logic [3:0] mask, input int hold, input logic [3:0] ew,
                       input logic [31:0] ef, input logic [11:0] ep, input logic eu);
    exp_t e;
    e.w = ew; e.f = ef; e.p = ep; e.u = eu;
    sb.push_back(e);
    @(negedge clk);
    keys = keys & ~mask;
    for (int i = 1; i <= hold; i++) begin
      @(posedge clk); #1;
      if (i == LAT) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $error("FAIL sb_empty: observed 0 entries expected 1");
        end else begin
          e = sb.pop_front();
          chk("upd_at_lat", {31'd0, param_upd}, {31'd0, e.u});
          cur = e;
          chk_words("after_press");
        end
      end else begin
        chk("upd_idle", {31'd0, param_upd}, 32'd0);
        if (i < LAT) chk_words("before_press");
      end
    end
    @(negedge clk);
    keys = 4'hF;
    repeat (10) begin
      @(posedge clk); #1;
      chk("upd_release", {31'd0, param_upd}, 32'd0);
      chk_words("release");
    end
  endtask

  initial begin
    rstn  = 1'b0;
    keys  = 4'hF;
    cur.w = 4'b0001; cur.f = 32'd86; cur.p = 12'd0; cur.u = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_words("reset");
    chk("reset_upd", {31'd0, param_upd}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;

    // Waveform rotation
    press(4'b0001, 20, 4'b0010, 86, 0, 1);
    press(4'b0001, 20, 4'b0100, 86, 0, 1);
    press(4'b0001, 20, 4'b1000, 86, 0, 1);
    press(4'b0001, 20, 4'b0001, 86, 0, 1);
    press(4'b0001, 20, 4'b0010, 86, 0, 1);

    // Move frequency, then reset asynchronously between clock edges
    press(4'b0010, 20, 4'b0010, 172, 0, 1);
    press(4'b0010, 20, 4'b0010, 258, 0, 1);
    @(posedge clk); #2;
    rstn = 1'b0;
    #1;
    cur.w = 4'b0001; cur.f = 32'd86; cur.p = 12'd0;
    chk_words("async_reset");
    chk("async_reset_upd", {31'd0, param_upd}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;

    // Frequency up with clamp
    press(4'b0010, 20, 4'b0001, 172, 0, 1);
    press(4'b0010, 20, 4'b0001, 258, 0, 1);
    press(4'b0010, 20, 4'b0001, 300, 0, 1);
    press(4'b0010, 20, 4'b0001, 300, 0, 0);
    // Frequency down with floor
    press(4'b0100, 20, 4'b0001, 214, 0, 1);
    press(4'b0100, 20, 4'b0001, 128, 0, 1);
    press(4'b0100, 20, 4'b0001, 86,  0, 1);
    press(4'b0100, 20, 4'b0001, 86,  0, 0);
    press(4'b0100, 20, 4'b0001, 86,  0, 0);

    // Phase wrap
    press(4'b1000, 20, 4'b0001, 86, 1024, 1);
    press(4'b1000, 20, 4'b0001, 86, 2048, 1);
    press(4'b1000, 20, 4'b0001, 86, 3072, 1);
    press(4'b1000, 20, 4'b0001, 86, 0,    1);
    press(4'b1000, 20, 4'b0001, 86, 1024, 1);

    // Glitch shorter than the debounce window
    @(negedge clk);
    keys[1] = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    keys = 4'hF;
    repeat (15) begin
      @(posedge clk); #1;
      chk("glitch_upd", {31'd0, param_upd}, 32'd0);
      chk_words("glitch");
    end

    // up + down cancel, phase still advances, single update pulse
    press(4'b1110, 20, 4'b0001, 86, 2048, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dds_param_ctrl.md
DDS_PARAM_CTRL -- requirements
Module: dds_param_ctrl

Interface
REQ-001 SHALL have parameter N, default 32, width of the frequency tuning word.
REQ-002 SHALL have parameter M, default 12, width of the phase offset word.
REQ-003 SHALL have parameter DEBOUNCE_CYCLES, default 1000000, the number of consecutive stable clocks required before a key change is accepted (20 ms at 50 MHz).
REQ-004 SHALL have parameter FRE_INIT, default 86, the reset frequency word (about 1 kHz at 50 MHz).
REQ-005 SHALL have parameter FRE_INC, default 86, the frequency word step per key press.
REQ-006 SHALL have parameter FRE_MAX, default 858993459, the upper frequency word limit (about 10 MHz at 50 MHz).
REQ-007 SHALL have parameter PHA_INC, default 1024, the phase word step per key press (90 degrees at M=12).
REQ-008 SHALL have the following ports, clock and reset first:
- clk  input  1  single system clock; all logic on rising edge.
- rstn  input  1  asynchronous active-low reset.
- key_wave  input  1  raw active-low button; press selects the next waveform.
- key_fre_up  input  1  raw active-low button; press increases frequency.
- key_fre_dn  input  1  raw active-low button; press decreases frequency.
- key_pha  input  1  raw active-low button; press advances phase.
- wave_sel  output  4  one-hot waveform select: 0001 sin, 0010 square, 0100 triangle, 1000 sawtooth.
- fre_step  output  N  frequency tuning word for the downstream DDS core.
- pha_step  output  M  phase offset word for the downstream DDS core.
- param_upd  output  1  one-clock pulse whenever any of wave_sel, fre_step or pha_step changes value.
REQ-009 SHALL drive every output directly from a register.

Function
REQ-010 SHALL pass each key through a 2-flop synchronizer, and its second stage SHALL be the only stage used by the following logic.
REQ-011 SHALL keep one debounce counter and one stable-level register per key; the counter SHALL clear on any cycle where the synchronized level equals the stable level, and SHALL otherwise increment.
REQ-012 SHALL load the synchronized level into the stable level, and clear the counter, on the edge where the counter equals DEBOUNCE_CYCLES-1 while the levels still differ.
REQ-013 SHALL generate a one-clock press pulse only on a stable-level transition from 1 to 0; a release (0 to 1) SHALL generate no pulse.
REQ-014 SHALL update the output registers on the clock edge after the press pulse. For a raw key held low, the outputs SHALL change exactly DEBOUNCE_CYCLES+3 rising edges after the first edge that samples the key low.
REQ-015 SHALL reject glitches: a raw low pulse shorter than DEBOUNCE_CYCLES clocks SHALL produce no output change.
REQ-016 SHALL rotate wave_sel on a wave press: 0001 -> 0010 -> 0100 -> 1000 -> 0001.
REQ-017 SHALL set wave_sel to 0001 on the next wave press if wave_sel ever holds a non-one-hot value.
REQ-018 SHALL set fre_step to min(fre_step+FRE_INC, FRE_MAX) on a fre_up press; the sum SHALL be computed N+1 bits wide so that overflow cannot wrap.
REQ-019 SHALL set fre_step to FRE_INC on a fre_dn press when fre_step is at or below 2*FRE_INC, and to fre_step-FRE_INC otherwise; fre_step SHALL never be 0.
REQ-020 SHALL leave fre_step unchanged when fre_up and fre_dn press pulses occur in the same cycle.
REQ-021 SHALL set pha_step to (pha_step+PHA_INC) mod 2^M on a pha press, wrapping silently.
REQ-022 SHALL apply press pulses on different functions in the same cycle independently, all in that same cycle.
REQ-023 SHALL assert param_upd for exactly the one cycle in which an output register takes a new value. Saturated presses that leave the value unchanged SHALL NOT assert param_upd.

Reset
REQ-024 SHALL, while rstn=0 and independent of clk, set wave_sel=0001, fre_step=FRE_INIT, pha_step=0 and param_upd=0.
REQ-025 SHALL, while rstn=0, clear all debounce counters and set the synchronizer and stable-level registers to 1 (released).
REQ-026 SHALL NOT produce a press pulse after reset is released with a key already held low; the outputs SHALL change only after the full debounce period.

Verification (DEBOUNCE_CYCLES=4, FRE_INIT=FRE_INC=86, FRE_MAX=300, PHA_INC=1024)
REQ-027 SHALL check: reset asserted mid-run with fre_step=258 -> wave_sel=0001, fre_step=86, pha_step=0 immediately, without waiting for a clock edge.
REQ-028 SHALL check: key_wave held low 5 times, each press 20 clocks long -> wave_sel goes 0010, 0100, 1000, 0001, 0010. Each change lands exactly 7 edges after the key falls, with one param_upd pulse per change.
REQ-029 SHALL check: fre_up pressed 4 times from reset -> fre_step goes 172, 258, 300, 300; the fourth press gives no param_upd. Then fre_dn pressed 5 times -> fre_step goes 214, 128, 86, 86, 86.
REQ-030 SHALL check: key_pha pressed 5 times -> pha_step goes 1024, 2048, 3072, 0, 1024.
REQ-031 SHALL check: key_fre_up low for 3 clocks, then high -> no output change and no param_upd.
REQ-032 SHALL check: key_fre_up and key_fre_dn fall on the same edge together with key_pha -> fre_step unchanged, pha_step advanced, and exactly one param_upd pulse.
